// File: rtl/ddr_target_frame_decoder_pkg.sv
`default_nettype none
// ============================================================================
// DDR_TARGET_PACKAGE : shared types and constants for the HDR-DDR target decoder. Rev 1.0
// ============================================================================
package DDR_TARGET_PACKAGE;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRE       = 3'd1,
      ST_PAYLOAD   = 3'd2,
      ST_PARITY    = 3'd3,
      ST_CRC_TOKEN = 3'd4,
      ST_CRC_VAL   = 3'd5,
      ST_DONE      = 3'd6,
      ST_ERROR     = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      WT_CMD  = 2'd0,
      WT_DATA = 2'd1,
      WT_CRC  = 2'd2
   } word_type_t;

   localparam logic [1:0] PRE_CMD   = 2'b01;
   localparam logic [1:0] PRE_DATA  = 2'b10;
   localparam logic [3:0] CRC_TOKEN = 4'hC;
   localparam logic [4:0] CRC_INIT  = 5'h1F;

   localparam int ERR_PARITY   = 0;
   localparam int ERR_PREAMBLE = 1;
   localparam int ERR_CRC      = 2;
   localparam int ERR_OVERFLOW = 3;

   // {P1, P0}: P1 covers odd data bits, P0 covers even data bits with a forced 1
   function automatic logic [1:0] ddr_parity(input logic [15:0] d);
      logic p1;
      logic p0;
      p1 = 1'b0;
      p0 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         p1 = p1 ^ d[2*i+1];
         p0 = p0 ^ d[2*i];
      end
      return {p1, p0};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_target_frame_decoder_crc5.sv
`default_nettype none
// ============================================================================
// ddr_crc5_serial : bit-serial CRC-5 (x^5+x^2+1), MSB first. Rev 1.0
// ============================================================================
module ddr_crc5_serial
   import DDR_TARGET_PACKAGE::*;
(
   input  logic       i_sys_clk,
   input  logic       i_sys_rst,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic       i_bit,
   output logic [4:0] o_crc
);

   logic [4:0] r_crc;
   logic       w_fb;

   assign w_fb  = r_crc[4] ^ i_bit;
   assign o_crc = r_crc;

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst || i_clr) begin
         r_crc <= CRC_INIT;
      end else if (i_en) begin
         r_crc <= {r_crc[3:0], 1'b0} ^ ({5{w_fb}} & 5'b00101);
      end
   end

endmodule
`default_nettype wire

// File: rtl/ddr_target_frame_decoder.sv
`default_nettype none
// ============================================================================
// ddr_target_frame_decoder : HDR-DDR target word decoder (preamble/parity/CRC-5). Rev 1.0
// ============================================================================
module ddr_target_frame_decoder
   import DDR_TARGET_PACKAGE::*;
#(
   parameter int MAX_WORDS = 16
) (
   input  logic        i_sys_clk,
   input  logic        i_sys_rst,
   input  logic        i_en,
   input  logic        i_scl_pos_edge,
   input  logic        i_scl_neg_edge,
   input  logic        i_sda,
   output logic        o_word_valid,
   output logic [1:0]  o_word_type,
   output logic [15:0] o_word_data,
   output logic        o_cmd_rnw,
   output logic [6:0]  o_cmd_code,
   output logic [6:0]  o_cmd_addr,
   output logic        o_read_req,
   output logic        o_frame_done,
   output logic [3:0]  o_err_status,
   output logic [4:0]  o_word_cnt
);

   localparam logic [4:0] C_MAX_WORDS = 5'(MAX_WORDS);

   state_t      r_state,   w_state_nxt;
   logic [4:0]  r_bitcnt,  w_bitcnt_nxt;
   logic [15:0] r_shift,   w_shift_nxt, w_shifted;
   logic [15:0] r_payload, w_payload_nxt;
   logic        r_first,   w_first_nxt;
   logic        r_is_data, w_is_data_nxt;
   logic        r_valid,   w_valid_nxt;
   word_type_t  r_type,    w_type_nxt;
   logic [15:0] r_data,    w_data_nxt;
   logic        r_rnw,     w_rnw_nxt;
   logic [6:0]  r_code,    w_code_nxt;
   logic [6:0]  r_addr,    w_addr_nxt;
   logic        r_rreq,    w_rreq_nxt;
   logic        r_done,    w_done_nxt;
   logic [3:0]  r_err,     w_err_nxt;
   logic [4:0]  r_cnt,     w_cnt_nxt;
   logic        w_sample, w_crc_clr, w_crc_en;
   logic [4:0]  w_crc;

   // Coincident strobes collapse to a single sample
   assign w_sample  = i_scl_pos_edge | i_scl_neg_edge;
   assign w_shifted = {r_shift[14:0], i_sda};

   ddr_crc5_serial u_crc (
      .i_sys_clk (i_sys_clk),
      .i_sys_rst (i_sys_rst),
      .i_clr     (w_crc_clr),
      .i_en      (w_crc_en),
      .i_bit     (i_sda),
      .o_crc     (w_crc)
   );

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         r_state   <= ST_IDLE;
         r_bitcnt  <= 5'd0;
         r_shift   <= 16'd0;
         r_payload <= 16'd0;
         r_first   <= 1'b0;
         r_is_data <= 1'b0;
         r_valid   <= 1'b0;
         r_type    <= WT_CMD;
         r_data    <= 16'd0;
         r_rnw     <= 1'b0;
         r_code    <= 7'd0;
         r_addr    <= 7'd0;
         r_rreq    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 4'd0;
         r_cnt     <= 5'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_bitcnt  <= w_bitcnt_nxt;
         r_shift   <= w_shift_nxt;
         r_payload <= w_payload_nxt;
         r_first   <= w_first_nxt;
         r_is_data <= w_is_data_nxt;
         r_valid   <= w_valid_nxt;
         r_type    <= w_type_nxt;
         r_data    <= w_data_nxt;
         r_rnw     <= w_rnw_nxt;
         r_code    <= w_code_nxt;
         r_addr    <= w_addr_nxt;
         r_rreq    <= w_rreq_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
         r_cnt     <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_bitcnt_nxt  = r_bitcnt;
      w_shift_nxt   = r_shift;
      w_payload_nxt = r_payload;
      w_first_nxt   = r_first;
      w_is_data_nxt = r_is_data;
      w_valid_nxt   = 1'b0;
      w_type_nxt    = r_type;
      w_data_nxt    = r_data;
      w_rnw_nxt     = r_rnw;
      w_code_nxt    = r_code;
      w_addr_nxt    = r_addr;
      w_rreq_nxt    = r_rreq;
      w_err_nxt     = r_err;
      w_cnt_nxt     = r_cnt;
      w_crc_clr     = 1'b0;
      w_crc_en      = 1'b0;

      if (w_sample && (r_state inside {ST_PRE, ST_PAYLOAD, ST_PARITY, ST_CRC_TOKEN, ST_CRC_VAL})) begin
         w_shift_nxt  = w_shifted;
         w_bitcnt_nxt = r_bitcnt + 5'd1;
      end

      case (r_state)
         ST_IDLE: begin
            if (i_en) begin
               w_state_nxt  = ST_PRE;
               w_bitcnt_nxt = 5'd0;
               w_err_nxt    = 4'd0;
               w_cnt_nxt    = 5'd0;
               w_first_nxt  = 1'b1;
               w_crc_clr    = 1'b1;
            end
         end
         ST_PRE: begin
            if (w_sample && r_bitcnt == 5'd1) begin
               w_bitcnt_nxt = 5'd0;
               if (r_first) begin
                  if (w_shifted[1:0] == PRE_CMD) begin
                     w_state_nxt   = ST_PAYLOAD;
                     w_is_data_nxt = 1'b0;
                  end else begin
                     w_err_nxt[ERR_PREAMBLE] = 1'b1;
                     w_state_nxt             = ST_ERROR;
                  end
               end else if (w_shifted[1:0] == PRE_DATA) begin
                  w_state_nxt   = ST_PAYLOAD;
                  w_is_data_nxt = 1'b1;
               end else if (w_shifted[1:0] == PRE_CMD) begin
                  w_state_nxt = ST_CRC_TOKEN;
               end else begin
                  w_err_nxt[ERR_PREAMBLE] = 1'b1;
                  w_state_nxt             = ST_ERROR;
               end
            end
         end
         ST_PAYLOAD: begin
            if (w_sample) begin
               w_crc_en = 1'b1;
               if (r_bitcnt == 5'd15) begin
                  w_bitcnt_nxt  = 5'd0;
                  w_payload_nxt = w_shifted;
                  w_state_nxt   = ST_PARITY;
               end
            end
         end
         ST_PARITY: begin
            if (w_sample && r_bitcnt == 5'd1) begin
               w_bitcnt_nxt = 5'd0;
               if (w_shifted[1:0] != ddr_parity(r_payload)) begin
                  w_err_nxt[ERR_PARITY] = 1'b1;
                  w_state_nxt           = ST_ERROR;
               end else if (r_is_data) begin
                  if (r_cnt == C_MAX_WORDS) begin
                     w_err_nxt[ERR_OVERFLOW] = 1'b1;
                     w_state_nxt             = ST_ERROR;
                  end else begin
                     w_valid_nxt = 1'b1;
                     w_type_nxt  = WT_DATA;
                     w_data_nxt  = r_payload;
                     w_cnt_nxt   = r_cnt + 5'd1;
                     w_state_nxt = ST_PRE;
                  end
               end else begin
                  w_valid_nxt = 1'b1;
                  w_type_nxt  = WT_CMD;
                  w_data_nxt  = r_payload;
                  w_rnw_nxt   = r_payload[15];
                  w_code_nxt  = r_payload[14:8];
                  w_addr_nxt  = r_payload[7:1];
                  w_first_nxt = 1'b0;
                  if (r_payload[15]) begin
                     w_rreq_nxt  = 1'b1;
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_state_nxt = ST_PRE;
                  end
               end
            end
         end
         ST_CRC_TOKEN: begin
            if (w_sample && r_bitcnt == 5'd3) begin
               w_bitcnt_nxt = 5'd0;
               if (w_shifted[3:0] == CRC_TOKEN) begin
                  w_state_nxt = ST_CRC_VAL;
               end else begin
                  w_err_nxt[ERR_CRC] = 1'b1;
                  w_state_nxt        = ST_ERROR;
               end
            end
         end
         ST_CRC_VAL: begin
            if (w_sample && r_bitcnt == 5'd4) begin
               w_bitcnt_nxt = 5'd0;
               if (w_shifted[4:0] == w_crc) begin
                  w_valid_nxt = 1'b1;
                  w_type_nxt  = WT_CRC;
                  w_data_nxt  = {11'd0, w_crc};
                  w_state_nxt = ST_DONE;
               end else begin
                  w_err_nxt[ERR_CRC] = 1'b1;
                  w_state_nxt        = ST_ERROR;
               end
            end
         end
         default: begin
         end
      endcase

      // Dropping enable aborts the frame; sticky status and fields survive
      if (!i_en) begin
         w_state_nxt = ST_IDLE;
         w_valid_nxt = 1'b0;
         w_rreq_nxt  = 1'b0;
      end

      w_done_nxt = (w_state_nxt inside {ST_DONE, ST_ERROR}) &&
                   !(r_state inside {ST_DONE, ST_ERROR});
   end

   assign o_word_valid = r_valid;
   assign o_word_type  = r_type;
   assign o_word_data  = r_data;
   assign o_cmd_rnw    = r_rnw;
   assign o_cmd_code   = r_code;
   assign o_cmd_addr   = r_addr;
   assign o_read_req   = r_rreq;
   assign o_frame_done = r_done;
   assign o_err_status = r_err;
   assign o_word_cnt   = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ddr_target_frame_decoder.sv
`default_nettype none
// ============================================================================
// tb_ddr_target_frame_decoder : directed scoreboard bench for the HDR-DDR target decoder. Rev 1.0
// ============================================================================
module tb_ddr_target_frame_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_en = 1'b0;
   logic        i_scl_pos_edge = 1'b0;
   logic        i_scl_neg_edge = 1'b0;
   logic        i_sda = 1'b0;
   logic        o_word_valid;
   logic [1:0]  o_word_type;
   logic [15:0] o_word_data;
   logic        o_cmd_rnw;
   logic [6:0]  o_cmd_code;
   logic [6:0]  o_cmd_addr;
   logic        o_read_req;
   logic        o_frame_done;
   logic [3:0]  o_err_status;
   logic [4:0]  o_word_cnt;

   ddr_target_frame_decoder #(.MAX_WORDS(16)) dut (
      .i_sys_clk      (clk),
      .i_sys_rst      (rst),
      .i_en           (i_en),
      .i_scl_pos_edge (i_scl_pos_edge),
      .i_scl_neg_edge (i_scl_neg_edge),
      .i_sda          (i_sda),
      .o_word_valid   (o_word_valid),
      .o_word_type    (o_word_type),
      .o_word_data    (o_word_data),
      .o_cmd_rnw      (o_cmd_rnw),
      .o_cmd_code     (o_cmd_code),
      .o_cmd_addr     (o_cmd_addr),
      .o_read_req     (o_read_req),
      .o_frame_done   (o_frame_done),
      .o_err_status   (o_err_status),
      .o_word_cnt     (o_word_cnt)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [1:0]  typ;
      logic [15:0] data;
      logic        done;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   pol = 1'b1;
   bit   both_next = 1'b0;
   exp_t none;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t mk(input logic v, input logic [1:0] t, input logic [15:0] d, input logic dn);
      exp_t e;
      e.valid = v; e.typ = t; e.data = d; e.done = dn; e.cyc = 0;
      return e;
   endfunction

   function automatic logic [1:0] par(input logic [15:0] d);
      logic [1:0] p;
      p[1] = d[15] ^ d[13] ^ d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[3] ^ d[1];
      p[0] = d[14] ^ d[12] ^ d[10] ^ d[8] ^ d[6] ^ d[4] ^ d[2] ^ d[0] ^ 1'b1;
      return p;
   endfunction

   // Golden CRC-5, generator x^5+x^2+1, message bits MSB first
   function automatic logic [4:0] crc16(input logic [4:0] c, input logic [15:0] d);
      logic [4:0] r;
      logic       fb;
      r = c;
      for (int i = 15; i >= 0; i--) begin
         fb = r[4] ^ d[i];
         r  = {r[3], r[2], r[1] ^ fb, r[0], fb};
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Scoreboard consumer: every valid/done pulse must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (o_word_valid || o_frame_done) begin
         checks++;
         assert (sb.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_event valid=%0b done=%0b cyc=%0d expected none", o_word_valid, o_frame_done, cyc);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert ({o_word_valid, o_frame_done, cyc} === {e.valid, e.done, e.cyc}) else begin
               failures++;
               $error("FAIL event_timing valid/done/cyc observed=%0b/%0b/%0d expected=%0b/%0b/%0d",
                      o_word_valid, o_frame_done, cyc, e.valid, e.done, e.cyc);
            end
            if (e.valid) begin
               checks++;
               assert ({o_word_type, o_word_data} === {e.typ, e.data}) else begin
                  failures++;
                  $error("FAIL word_content type/data observed=%0d/%h expected=%0d/%h",
                         o_word_type, o_word_data, e.typ, e.data);
               end
            end
         end
      end
   end

   task automatic send_bit(input logic b, input bit push, input exp_t e);
      exp_t t;
      @(negedge clk);
      if (push) begin
         t = e;
         t.cyc = cyc + 1;
         sb.push_back(t);
      end
      i_sda = b;
      if (both_next) begin
         i_scl_pos_edge = 1'b1;
         i_scl_neg_edge = 1'b1;
         both_next = 1'b0;
      end else begin
         i_scl_pos_edge = pol;
         i_scl_neg_edge = !pol;
      end
      pol = !pol;
      @(negedge clk);
      i_scl_pos_edge = 1'b0;
      i_scl_neg_edge = 1'b0;
   endtask

   task automatic send_field(input logic [15:0] v, input int n, input bit push, input exp_t e);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i], push && (i == 0), e);
   endtask

   task automatic send_word(input logic [1:0] pre, input logic [15:0] d, input logic [1:0] p,
                            input bit push, input exp_t e);
      send_field({14'd0, pre}, 2, 1'b0, none);
      send_field(d, 16, 1'b0, none);
      send_field({14'd0, p}, 2, push, e);
   endtask

   task automatic start_frame();
      @(negedge clk);
      i_en = 1'b1;
      @(negedge clk);
   endtask

   task automatic end_frame();
      @(negedge clk);
      i_en = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [4:0]  crc;
      logic [15:0] d;
      none = mk(1'b0, 2'd0, 16'd0, 1'b0);

      repeat (3) @(negedge clk);
      chk("reset_valid_done", {31'd0, o_word_valid | o_frame_done}, 32'd0);
      chk("reset_fields", {o_word_data, o_cmd_code, o_cmd_addr, o_cmd_rnw, o_read_req}, 32'd0);
      chk("reset_err_cnt", {23'd0, o_err_status, o_word_cnt}, 32'd0);
      rst = 1'b0;

      // Write command, one data word, good CRC; first bit uses coincident strobes
      crc = crc16(crc16(5'h1F, 16'h1A52), 16'hA5A5);
      start_frame();
      both_next = 1'b1;
      send_word(2'b01, 16'h1A52, par(16'h1A52), 1'b1, mk(1'b1, 2'd0, 16'h1A52, 1'b0));
      chk("wr_cmd_rnw", {31'd0, o_cmd_rnw}, 32'd0);
      chk("wr_cmd_code", {25'd0, o_cmd_code}, 32'h1A);
      chk("wr_cmd_addr", {25'd0, o_cmd_addr}, 32'h29);
      chk("wr_read_req", {31'd0, o_read_req}, 32'd0);
      send_word(2'b10, 16'hA5A5, par(16'hA5A5), 1'b1, mk(1'b1, 2'd1, 16'hA5A5, 1'b0));
      chk("wr_word_cnt", {27'd0, o_word_cnt}, 32'd1);
      send_field(16'h0001, 2, 1'b0, none);
      send_field(16'h000C, 4, 1'b0, none);
      send_field({11'd0, crc}, 5, 1'b1, mk(1'b1, 2'd2, {11'd0, crc}, 1'b1));
      chk("wr_err_ok", {28'd0, o_err_status}, 32'd0);
      end_frame();

      // Data payload bit flipped: parity error, done right after last parity bit
      start_frame();
      send_word(2'b01, 16'h1A52, par(16'h1A52), 1'b1, mk(1'b1, 2'd0, 16'h1A52, 1'b0));
      send_word(2'b10, 16'hA5A4, par(16'hA5A5), 1'b1, mk(1'b0, 2'd0, 16'd0, 1'b1));
      chk("par_err", {28'd0, o_err_status}, 32'h1);
      chk("par_word_cnt", {27'd0, o_word_cnt}, 32'd0);
      end_frame();

      // Bad command preamble
      start_frame();
      send_field(16'h0003, 2, 1'b1, mk(1'b0, 2'd0, 16'd0, 1'b1));
      send_field(16'h5555, 8, 1'b0, none);
      chk("pre_err", {28'd0, o_err_status}, 32'h2);
      end_frame();

      // Last CRC bit inverted
      start_frame();
      send_word(2'b01, 16'h1A52, par(16'h1A52), 1'b1, mk(1'b1, 2'd0, 16'h1A52, 1'b0));
      send_word(2'b10, 16'hA5A5, par(16'hA5A5), 1'b1, mk(1'b1, 2'd1, 16'hA5A5, 1'b0));
      send_field(16'h0001, 2, 1'b0, none);
      send_field(16'h000C, 4, 1'b0, none);
      send_field({11'd0, crc ^ 5'h01}, 5, 1'b1, mk(1'b0, 2'd0, 16'd0, 1'b1));
      chk("crc_err", {28'd0, o_err_status}, 32'h4);
      end_frame();

      // Read command: handoff, later strobes ignored
      start_frame();
      send_word(2'b01, 16'h9A52, par(16'h9A52), 1'b1, mk(1'b1, 2'd0, 16'h9A52, 1'b1));
      chk("rd_cmd_rnw", {31'd0, o_cmd_rnw}, 32'd1);
      chk("rd_read_req", {31'd0, o_read_req}, 32'd1);
      send_word(2'b10, 16'h1234, par(16'h1234), 1'b0, none);
      chk("rd_hold_req", {31'd0, o_read_req}, 32'd1);
      chk("rd_hold_cnt_err", {23'd0, o_err_status, o_word_cnt}, 32'd0);
      end_frame();
      chk("rd_req_cleared", {31'd0, o_read_req}, 32'd0);

      // Seventeen data words against a limit of sixteen
      start_frame();
      send_word(2'b01, 16'h1A52, par(16'h1A52), 1'b1, mk(1'b1, 2'd0, 16'h1A52, 1'b0));
      for (int i = 0; i < 16; i++) begin
         d = 16'h1357 * 16'(i + 1);
         send_word(2'b10, d, par(d), 1'b1, mk(1'b1, 2'd1, d, 1'b0));
      end
      chk("ovf_cnt16", {27'd0, o_word_cnt}, 32'd16);
      chk("ovf_no_err_yet", {28'd0, o_err_status}, 32'd0);
      send_word(2'b10, 16'h0F0F, par(16'h0F0F), 1'b1, mk(1'b0, 2'd0, 16'd0, 1'b1));
      chk("ovf_err", {28'd0, o_err_status}, 32'h8);
      chk("ovf_cnt_kept", {27'd0, o_word_cnt}, 32'd16);
      end_frame();

      // Reset in the middle of a data payload
      start_frame();
      send_word(2'b01, 16'h1A52, par(16'h1A52), 1'b1, mk(1'b1, 2'd0, 16'h1A52, 1'b0));
      send_field(16'h0002, 2, 1'b0, none);
      send_field(16'h00FF, 5, 1'b0, none);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_fields", {o_word_data, o_cmd_code, o_cmd_addr, o_cmd_rnw, o_read_req}, 32'd0);
      chk("rst_mid_status", {22'd0, o_word_valid, o_frame_done, o_err_status, o_word_cnt}, 32'd0);
      rst = 1'b0;
      i_en = 1'b0;
      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
